// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter and its bench.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } limit_mode_e;

    localparam int unsigned MAX_WIDTH = 32;

    // Out-of-range requests are pulled down to the modulus limit rather than wrapped.
    function automatic logic [MAX_WIDTH-1:0] clamp_to_max(
        input logic [MAX_WIDTH-1:0] value,
        input logic [MAX_WIDTH-1:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/updown_mod_next.sv
// Combinational next-count and limit-event logic for updown_mod_counter.
module updown_mod_next
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter limit_mode_e      MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  dir_e             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             limit
);

    // One extra bit so MAX_VAL = 2**WIDTH-1 and the 0-1 borrow are both visible.
    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] max_ext;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;

    assign count_ext = {1'b0, count};
    assign max_ext   = {1'b0, MAX_VAL};
    assign inc       = count_ext + (WIDTH + 1)'(1);
    assign dec       = count_ext - (WIDTH + 1)'(1);

    always_comb begin
        next_count = count;
        limit      = 1'b0;
        unique case (dir)
            DIR_UP: begin
                if (inc > max_ext) begin
                    limit      = 1'b1;
                    next_count = (MODE == MODE_SAT) ? MAX_VAL : '0;
                end else begin
                    next_count = inc[WIDTH-1:0];
                end
            end
            DIR_DOWN: begin
                if (dec[WIDTH]) begin
                    limit      = 1'b1;
                    next_count = (MODE == MODE_SAT) ? '0 : MAX_VAL;
                end else begin
                    next_count = dec[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus, load, enable and wrap/saturate mode.
// Optional sticky limit flag is built when COUNTER_OVF_STICKY_EN is defined.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam limit_mode_e MODE = SATURATE ? MODE_SAT : MODE_WRAP;

    // A misconfigured reset value must not put the counter outside its range.
    localparam logic [WIDTH-1:0] RESET_SAFE = (RESET_VAL > MAX_VAL) ? MAX_VAL : RESET_VAL;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_count;
    logic             step_limit;
    logic [WIDTH-1:0] load_clamped;
    dir_e             dir;

    assign dir          = up_dn ? DIR_UP : DIR_DOWN;
    assign load_clamped = WIDTH'(clamp_to_max(MAX_WIDTH'(load_val), MAX_WIDTH'(MAX_VAL)));

    updown_mod_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .MODE    (MODE)
    ) u_next (
        .count      (count_q),
        .dir        (dir),
        .next_count (step_count),
        .limit      (step_limit)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            count_d = step_count;
            wrap_d  = step_limit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_SAFE;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // A new limit event outranks a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wrap_d) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

endmodule
